// File: rtl/ex_flag_branch_stage.sv
// EX->MEM boundary: latches ALU result, owns N/Z/V flags,
// resolves conditional branches and squashes the wrong path.
module ex_flag_branch_stage #(
  parameter logic [5:0]  BR_OPCODE     = 6'h10,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_cond,
  input  logic [31:0] ex_target,
  input  logic [31:0] alu_out,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic        mem_wr_en,
  output logic [31:0] mem_result,
  output logic [4:0]  mem_rd,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        squashing
);

  typedef enum logic {RUN, SQUASH} state_e;

  localparam logic [2:0] SQ_CNT = 3'(SQUASH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, wr_en_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        n_q, z_q, v_q;
  logic        taken_q;
  logic [31:0] target_q;

  logic advance, live;
  logic is_flag, is_wr, is_br;
  logic cond_ok, take;

  assign advance = ~stall;
  assign live    = ex_valid & advance & ~flush & (state_q == RUN);
  assign is_br   = (ex_opcode == BR_OPCODE);
  assign take    = live & is_br & cond_ok;

  always_comb begin
    is_flag = 1'b0;
    case (ex_opcode)
      6'h00, 6'h01, 6'h02, 6'h03,
      6'h04, 6'h22, 6'h23: is_flag = 1'b1;
      default:             is_flag = 1'b0;
    endcase
  end

  assign is_wr = is_flag
               | (ex_opcode == 6'h05)
               | (ex_opcode == 6'h06);

  // Conditions read the committed flags, never the live ALU flags.
  always_comb begin
    cond_ok = 1'b0;
    unique case (ex_cond)
      3'd0: cond_ok = ~z_q;
      3'd1: cond_ok = z_q;
      3'd2: cond_ok = ~z_q & ~n_q;
      3'd3: cond_ok = n_q;
      3'd4: cond_ok = ~n_q;
      3'd5: cond_ok = n_q | z_q;
      3'd6: cond_ok = v_q;
      3'd7: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (advance) begin
      unique case (state_q)
        RUN: begin
          if (take) begin
            state_d = SQUASH;
            cnt_d   = SQ_CNT;
          end
        end
        SQUASH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taken_q <= take;
      if (take) begin
        target_q <= ex_target;
      end
      if (advance) begin
        valid_q  <= live;
        wr_en_q  <= live & is_wr;
        result_q <= alu_out;
        rd_q     <= ex_rd;
      end
      if (live & is_flag) begin
        n_q <= alu_n;
        z_q <= alu_z;
        v_q <= alu_v;
      end
    end
  end

  assign mem_valid  = valid_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_result = result_q;
  assign mem_rd     = rd_q;
  assign flag_n     = n_q;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign br_taken   = taken_q;
  assign br_target  = target_q;
  assign squashing  = (state_q == SQUASH);

endmodule
